seq_restoring_divider: RTL and testbench

- Unsigned sequential restoring divider: dividend / divisor -> quotient, remainder, one quotient bit per clock.
- Inverse datapath to the multiplier/adder arithmetic; reuses carry-lookahead style subtraction for the trial step.
- Sits beside the variable-precision multiplier as the datapath's divide unit.
- Valid/ready handshake on both input and output.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_trial_subtractor.sv | 51 +++++
 rtl/seq_restoring_divider.sv | 119 +++++++++++
 tb/tb_seq_restoring_divider.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } div_state_e;

    // Counter must hold WIDTH itself, hence the +1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_trial_subtractor.sv
// (N)-bit subtractor a - b built as a + ~b + 1 with a Kogge-Stone carry-lookahead prefix tree.
module div_trial_subtractor #(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o,
    output logic         borrow_o
);

    localparam int unsigned Lvls = $clog2(N);

    logic [N-1:0]          b_inv;
    logic [N-1:0]          gen;
    logic [N-1:0]          prop;
    logic [Lvls:0][N-1:0]  grp_g;
    logic [Lvls:0][N-1:0]  grp_p;
    logic [N:0]            carry;
    logic                  unused_grp_p;

    assign b_inv = ~b_i;
    assign gen   = a_i & b_inv;
    assign prop  = a_i ^ b_inv;

    // The +1 carry-in is folded into the bit-0 generate term.
    assign grp_g[0] = {gen[N-1:1], gen[0] | prop[0]};
    assign grp_p[0] = prop;

    for (genvar l = 1; l <= Lvls; l++) begin : g_level
        for (genvar i = 0; i < N; i++) begin : g_bit
            if (i >= (1 << (l - 1))) begin : g_comb
                assign grp_g[l][i] = grp_g[l-1][i]
                                   | (grp_p[l-1][i] & grp_g[l-1][i-(1<<(l-1))]);
                assign grp_p[l][i] = grp_p[l-1][i] & grp_p[l-1][i-(1<<(l-1))];
            end else begin : g_pass
                assign grp_g[l][i] = grp_g[l-1][i];
                assign grp_p[l][i] = grp_p[l-1][i];
            end
        end
    end

    assign carry[0] = 1'b1;
    for (genvar i = 0; i < N; i++) begin : g_sum
        assign carry[i+1] = grp_g[Lvls][i];
        assign diff_o[i]  = prop[i] ^ carry[i];
    end

    assign borrow_o     = ~carry[N];
    assign unused_grp_p = ^grp_p[Lvls];

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider: one quotient bit per clock, valid/ready on both sides.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned      CNT_W   = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CntInit = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(1);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;
    logic             out_valid_q;

    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_b;
    logic [WIDTH:0]   trial_diff;
    logic             trial_borrow;
    logic [WIDTH:0]   r_d;
    logic [WIDTH-1:0] q_d;
    logic             unused_r_msb;

    assign trial_a = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign trial_b = {1'b0, divisor_q};

    div_trial_subtractor #(
        .N (WIDTH + 1)
    ) u_trial (
        .a_i      (trial_a),
        .b_i      (trial_b),
        .diff_o   (trial_diff),
        .borrow_o (trial_borrow)
    );

    // Restore on borrow: keep the shifted partial remainder instead of the difference.
    assign r_d = trial_borrow ? trial_a : trial_diff;
    assign q_d = {q_q[WIDTH-2:0], ~trial_borrow};

    // R[WIDTH] only guards the trial subtraction; it is zero whenever a result is taken.
    assign unused_r_msb = r_q[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            divisor_q   <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        divisor_q <= divisor;
                        dbz_q     <= (divisor == '0);
                        if (divisor == '0) begin
                            quot_q      <= '1;
                            rem_q       <= dividend;
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            r_q     <= '0;
                            q_q     <= dividend;
                            cnt_q   <= CntInit;
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - CntLast;
                    if (cnt_q == CntLast) begin
                        quot_q      <= q_d;
                        rem_q       <= r_d[WIDTH-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = out_valid_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: WIDTH=8 directed + random, WIDTH=4 exhaustive.
module tb_seq_restoring_divider;

    localparam int unsigned W8 = 8;
    localparam int unsigned W4 = 4;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         lat;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       dbz;

    logic       v4 = 1'b0;
    logic       rdy4;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       ov4;
    logic       or4 = 1'b0;
    logic [3:0] q4;
    logic [3:0] r4;
    logic       z4;

    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   cyc = 0;
    int   rmode = 1;
    int   hold_cnt = 0;
    logic prev_valid = 1'b0;
    logic post_hs = 1'b0;
    logic [7:0] held_q, held_r;
    logic       held_z;
    exp_t exp_q[$];

    seq_restoring_divider #(.WIDTH(W8)) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (dbz)
    );

    seq_restoring_divider #(.WIDTH(W4)) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (v4),
        .in_ready    (rdy4),
        .dividend    (a4),
        .divisor     (b4),
        .out_valid   (ov4),
        .out_ready   (or4),
        .quotient    (q4),
        .remainder   (r4),
        .div_by_zero (z4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        chk_cnt++;
        if (got === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
    endtask

    task automatic note_fail(input string name);
        chk_cnt++;
        $display("FAIL %s: got timeout, required completion", name);
    endtask

    // Reference: plain / and %, with the divide-by-zero convention.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   g;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            note_fail("accept_wait");
        end else begin
            e.q   = (b == 0) ? 8'hFF : 8'(int'(a) / int'(b));
            e.r   = (b == 0) ? a : 8'(int'(a) % int'(b));
            e.dbz = (b == 0);
            e.lat = (b == 0) ? 0 : int'(W8);
            e.acc = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) note_fail("drain_wait");
        @(negedge clk);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b);
        int   g = 0;
        logic done = 1'b0;
        logic [3:0] eq, er;
        eq = (b == 0) ? 4'hF : 4'(int'(a) / int'(b));
        er = (b == 0) ? a : 4'(int'(a) % int'(b));
        a4 = a;
        b4 = b;
        v4 = 1'b1;
        while (!rdy4 && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        v4 = 1'b0;
        a4 = 4'($urandom);
        b4 = 4'($urandom);
        g = 0;
        while (!done && g < 60) begin
            if (ov4 && ($urandom % 2 == 0)) begin
                or4 = 1'b1;
                check("w4_quotient", q4, eq);
                check("w4_remainder", r4, er);
                check("w4_div_by_zero", z4, (b == 0));
                done = 1'b1;
            end
            @(negedge clk);
            or4 = 1'b0;
            g++;
        end
        if (!done) note_fail("w4_result_wait");
    endtask

    // Monitor: latency at rise, hold-stability under backpressure, pop+compare at handshake.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                post_hs    = 1'b0;
                hold_cnt   = 0;
                out_ready  = 1'b0;
            end else begin
                if (post_hs) begin
                    check("in_ready_after_handshake", in_ready, 1);
                    check("out_valid_after_handshake", out_valid, 0);
                    post_hs = 1'b0;
                end
                if (out_valid) begin
                    if (!prev_valid) begin
                        check("result_was_expected", (exp_q.size() != 0), 1);
                        if (exp_q.size() != 0)
                            check("latency", cyc - exp_q[0].acc, exp_q[0].lat);
                    end else begin
                        check("hold_quotient", quotient, held_q);
                        check("hold_remainder", remainder, held_r);
                        check("hold_div_by_zero", dbz, held_z);
                    end
                    held_q = quotient;
                    held_r = remainder;
                    held_z = dbz;
                    case (rmode)
                        1:       out_ready = 1'b1;
                        2:       out_ready = (hold_cnt >= 10);
                        default: out_ready = ($urandom % 3 != 0);
                    endcase
                    hold_cnt++;
                    if (out_ready) begin
                        post_hs = 1'b1;
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("quotient", quotient, e.q);
                            check("remainder", remainder, e.r);
                            check("div_by_zero", dbz, e.dbz);
                        end
                    end
                end else begin
                    hold_cnt  = 0;
                    out_ready = (rmode == 0) ? 1'($urandom % 2) : 1'b0;
                end
                prev_valid = out_valid && !out_ready;
            end
        end
    end

    initial begin : watchdog
        #900_000;
        note_fail("watchdog");
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin : main
        int g;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_div_by_zero", dbz, 0);
        rst_n = 1'b1;

        rmode = 1;
        issue(8'd100, 8'd7);
        drain();
        issue(8'd255, 8'd1);
        issue(8'd5, 8'd9);
        issue(8'd255, 8'd255);
        drain();
        issue(8'h5A, 8'd0);
        issue(8'd20, 8'd3);
        drain();

        // Backpressure with ignored in_valid pulses while busy.
        rmode = 2;
        issue(8'd200, 8'd13);
        g = 0;
        while (!in_ready && g < 60) begin
            in_valid = 1'b1;
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
            @(negedge clk);
            if (out_valid) check("busy_in_ready", in_ready, 0);
            g++;
        end
        in_valid = 1'b0;
        drain();
        rmode = 1;

        // Asynchronous reset in the middle of CALC.
        issue(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_in_ready", in_ready, 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(8'd9, 8'd2);
        drain();

        rmode = 0;
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] a, b;
            int sel;
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                if (!in_ready) begin
                    in_valid = 1'($urandom % 2);
                    dividend = 8'($urandom);
                    divisor  = 8'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            a   = 8'($urandom);
            sel = $urandom_range(0, 7);
            if (sel == 0)      b = 8'd0;
            else if (sel == 1) b = 8'($urandom_range(1, 15));
            else               b = 8'($urandom);
            issue(a, b);
        end
        drain();
        rmode = 1;

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run4(4'(a), 4'(b));
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
